cmd_decode_engine: RTL and testbench

Command decoder feeding addressing_engine and the generation engine. Accepts a byte stream over a valid/ready handshake and assembles FILL_RECT / SET_PIXEL commands into 16-bit fields. Issues a one-cycle addr_start_strobe, then stalls input until the generation engine reports completion.

---
 rtl/cmd_decode_engine.sv | 129 ++++++++++++
 tb/tb_cmd_decode_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decode_engine.sv
// rtl/cmd_decode_engine.sv - byte-stream FILL_RECT/SET_PIXEL decoder with issue strobe and completion wait
// Optional build macro: DECODE_RANGE_CHECK_EN (reject commands that fall outside MAX_X x MAX_Y).
module cmd_decode_engine #(
  parameter int MAX_X = 480,
  parameter int MAX_Y = 640
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        gen_done,
  output logic        addr_start_strobe,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_data_origx,
  output logic [15:0] cmd_data_origy,
  output logic [15:0] cmd_data_width,
  output logic [15:0] cmd_data_height,
  output logic [7:0]  cmd_data_color,
  output logic        cmd_busy,
  output logic        cmd_err,
  output logic [15:0] cmd_count
);

  localparam logic [7:0] OP_FILL_RECT = 8'h01;
  localparam logic [7:0] OP_SET_PIXEL = 8'h02;

  typedef enum logic [3:0] {
    IDLE, ORIGX_B1, ORIGX_B2, ORIGY_B1, ORIGY_B2, WIDTH_B1, WIDTH_B2,
    HEIGHT_B1, HEIGHT_B2, COLOR, ISSUE, WAIT
  } state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   err_nxt;
  logic   reject;

  assign in_ready = !rst_ && (state != ISSUE) && (state != WAIT);
  assign xfer     = in_valid && in_ready;

`ifdef DECODE_RANGE_CHECK_EN
  logic [16:0] x_end;
  logic [16:0] y_end;
  assign x_end  = {1'b0, cmd_data_origx} + {1'b0, cmd_data_height};
  assign y_end  = {1'b0, cmd_data_origy} + {1'b0, cmd_data_width};
  assign reject = (cmd_data_origx >= 16'(MAX_X)) || (cmd_data_origy >= 16'(MAX_Y)) ||
                  (x_end > 17'(MAX_X)) || (y_end > 17'(MAX_Y));
`else
  // Limits only matter when the range check is built in.
  logic unused_limits;
  assign unused_limits = ^{32'(MAX_X), 32'(MAX_Y)};
  assign reject        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        if (in_data == OP_FILL_RECT || in_data == OP_SET_PIXEL) state_nxt = ORIGX_B1;
        else err_nxt = 1'b1;
      end
      ORIGX_B1:  if (xfer) state_nxt = ORIGX_B2;
      ORIGX_B2:  if (xfer) state_nxt = ORIGY_B1;
      ORIGY_B1:  if (xfer) state_nxt = ORIGY_B2;
      ORIGY_B2:  if (xfer) state_nxt = (cmd_opcode == OP_SET_PIXEL) ? COLOR : WIDTH_B1;
      WIDTH_B1:  if (xfer) state_nxt = WIDTH_B2;
      WIDTH_B2:  if (xfer) state_nxt = HEIGHT_B1;
      HEIGHT_B1: if (xfer) state_nxt = HEIGHT_B2;
      HEIGHT_B2: if (xfer) state_nxt = COLOR;
      COLOR: if (xfer) begin
        if (reject) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (gen_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state             <= IDLE;
      addr_start_strobe <= 1'b0;
      cmd_busy          <= 1'b0;
      cmd_err           <= 1'b0;
      cmd_count         <= 16'd0;
      cmd_opcode        <= 8'd0;
      cmd_data_origx    <= 16'd0;
      cmd_data_origy    <= 16'd0;
      cmd_data_width    <= 16'd0;
      cmd_data_height   <= 16'd0;
      cmd_data_color    <= 8'd0;
    end else begin
      state             <= state_nxt;
      addr_start_strobe <= (state_nxt == ISSUE);
      cmd_busy          <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      cmd_err           <= err_nxt;
      if (state_nxt == ISSUE) cmd_count <= cmd_count + 16'd1;
      // Fields fill in place as bytes arrive, MSB byte first.
      if (xfer) begin
        case (state)
          IDLE: if (state_nxt == ORIGX_B1) begin
            cmd_opcode <= in_data;
            if (in_data == OP_SET_PIXEL) begin
              cmd_data_width  <= 16'd1;
              cmd_data_height <= 16'd1;
            end
          end
          ORIGX_B1:  cmd_data_origx[15:8]  <= in_data;
          ORIGX_B2:  cmd_data_origx[7:0]   <= in_data;
          ORIGY_B1:  cmd_data_origy[15:8]  <= in_data;
          ORIGY_B2:  cmd_data_origy[7:0]   <= in_data;
          WIDTH_B1:  cmd_data_width[15:8]  <= in_data;
          WIDTH_B2:  cmd_data_width[7:0]   <= in_data;
          HEIGHT_B1: cmd_data_height[15:8] <= in_data;
          HEIGHT_B2: cmd_data_height[7:0]  <= in_data;
          COLOR:     cmd_data_color        <= in_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_decode_engine.sv
// tb/tb_cmd_decode_engine.sv - scoreboard bench for cmd_decode_engine
module tb_cmd_decode_engine;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        gen_done = 1'b0;
  logic        in_ready;
  logic        addr_start_strobe;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_data_origx, cmd_data_origy, cmd_data_width, cmd_data_height;
  logic [7:0]  cmd_data_color;
  logic        cmd_busy, cmd_err;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  cmd_decode_engine dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gen_done(gen_done), .addr_start_strobe(addr_start_strobe), .cmd_opcode(cmd_opcode),
    .cmd_data_origx(cmd_data_origx), .cmd_data_origy(cmd_data_origy),
    .cmd_data_width(cmd_data_width), .cmd_data_height(cmd_data_height),
    .cmd_data_color(cmd_data_color), .cmd_busy(cmd_busy), .cmd_err(cmd_err),
    .cmd_count(cmd_count)
  );

  typedef struct {
    logic [7:0]  op;
    logic [15:0] x, y, w, h;
    logic [7:0]  c;
    logic [15:0] n;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  seq[$];
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          strobes = 0;
  int          exp_err_pulses = 0;
  logic [15:0] exp_count = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w, input logic [15:0] h, input logic [7:0] c);
    exp_t e;
    exp_count++;
    e.op = op; e.x = x; e.y = y; e.w = w; e.h = h; e.c = c; e.n = exp_count;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmd_err) err_pulses++;
    if (addr_start_strobe) begin
      strobes++;
      check_eq("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("opcode", cmd_opcode, e.op);
        check_eq("origx", cmd_data_origx, e.x);
        check_eq("origy", cmd_data_origy, e.y);
        check_eq("width", cmd_data_width, e.w);
        check_eq("height", cmd_data_height, e.h);
        check_eq("color", cmd_data_color, e.c);
        check_eq("count", cmd_count, e.n);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("ready_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input int maxgap);
    foreach (seq[i]) send_byte(seq[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic finish_cmd(input bit gd_on_strobe);
    check_eq("strobe_latency", addr_start_strobe, 1);
    check_eq("ready_in_issue", in_ready, 0);
    check_eq("busy_in_issue", cmd_busy, 1);
    gen_done = gd_on_strobe;
    @(negedge clk);
    gen_done = 1'b0;
    check_eq("strobe_one_cycle", addr_start_strobe, 0);
    check_eq("busy_in_wait", cmd_busy, 1);
    check_eq("ready_in_wait", in_ready, 0);
    repeat (2) @(negedge clk);
    check_eq("still_waiting", cmd_busy, 1);
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    check_eq("busy_cleared", cmd_busy, 0);
    check_eq("ready_after_done", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_strobe"}, addr_start_strobe, 0);
    check_eq({tag, "_busy"}, cmd_busy, 0);
    check_eq({tag, "_err"}, cmd_err, 0);
    check_eq({tag, "_count"}, cmd_count, 0);
    check_eq({tag, "_fields"}, {cmd_opcode, cmd_data_origx, cmd_data_color}, 0);
    check_eq({tag, "_dims"}, {cmd_data_width, cmd_data_height}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int e0;

    // Reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", in_ready, 1);
    check_eq("count_after_reset", cmd_count, 0);

    // FILL_RECT back-to-back
    push_exp(8'h01, 16'd10, 16'd20, 16'd32, 16'd16, 8'h3C);
    seq = '{8'h01, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h20, 8'h00, 8'h10, 8'h3C};
    send_seq(0);
    finish_cmd(1'b0);
    check_eq("count_after_fill", cmd_count, 1);

    // SET_PIXEL at the far corner with random gaps
    push_exp(8'h02, 16'd479, 16'd639, 16'd1, 16'd1, 8'hFF);
    seq = '{8'h02, 8'h01, 8'hDF, 8'h02, 8'h7F, 8'hFF};
    send_seq(3);
    finish_cmd(1'b0);

    // Illegal opcode, then a legal SET_PIXEL
    s0 = strobes;
    seq = '{8'h07};
    send_seq(0);
    exp_err_pulses++;
    check_eq("illegal_err_pulse", cmd_err, 1);
    check_eq("illegal_ready", in_ready, 1);
    check_eq("illegal_opcode_held", cmd_opcode, 8'h02);
    check_eq("illegal_color_held", cmd_data_color, 8'hFF);
    @(negedge clk);
    check_eq("illegal_err_one_cycle", cmd_err, 0);
    check_eq("illegal_no_strobe", strobes, s0);
    push_exp(8'h02, 16'd0, 16'd0, 16'd1, 16'd1, 8'h11);
    seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
    send_seq(1);
    finish_cmd(1'b0);
    check_eq("count_after_three", cmd_count, 3);

    // Reset after the ORIGY_B1 byte discards the partial command
    s0 = strobes;
    seq = '{8'h01, 8'h00, 8'h05, 8'h00};
    send_seq(0);
    rst_ = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_ = 1'b0;
    exp_count = 16'd0;
    repeat (15) @(negedge clk);
    check_eq("midreset_no_strobe", strobes, s0);
    check_eq("midreset_ready", in_ready, 1);

    // gen_done coincident with the strobe is ignored
    push_exp(8'h01, 16'd1, 16'd2, 16'd3, 16'd4, 8'hAA);
    seq = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'hAA};
    send_seq(2);
    finish_cmd(1'b1);

    // Range: origx 470 + height 20 exceeds 480 rows
    s0 = strobes;
    e0 = err_pulses;
    seq = '{8'h01, 8'h01, 8'hD6, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h55};
`ifdef DECODE_RANGE_CHECK_EN
    send_seq(0);
    exp_err_pulses++;
    check_eq("range_err", cmd_err, 1);
    check_eq("range_no_strobe", addr_start_strobe, 0);
    check_eq("range_ready", in_ready, 1);
    @(negedge clk);
    check_eq("range_count_held", cmd_count, exp_count);
    check_eq("range_strobes", strobes, s0);
    check_eq("range_err_count", err_pulses, e0 + 1);
`else
    push_exp(8'h01, 16'd470, 16'd0, 16'd10, 16'd20, 8'h55);
    send_seq(0);
    finish_cmd(1'b0);
    check_eq("range_strobes", strobes, s0 + 1);
    check_eq("range_no_err", err_pulses, e0);
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("err_pulse_total", err_pulses, exp_err_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
